// File: rtl/AESDefinitions.sv
// Shared AES data types: a state is 16 bytes, with byte 4c+r at column c, row r.
package AESDefinitions;
    localparam int AES_STATE_SIZE = 16;

    typedef logic [7:0] byte_t;
    typedef byte_t [AES_STATE_SIZE-1:0] state_t;
    typedef byte_t [3:0] column_t;
endpackage

// File: rtl/GaloisFieldFunctions.sv
// GF(2^8) helpers over polynomial 0x11B, built only from xtime and XOR.
package GaloisFieldFunctions;
    import AESDefinitions::*;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t GfMult9(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic byte_t GfMult11(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic byte_t GfMult13(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic byte_t GfMult14(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction
endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns on one 4-byte column; row r uses the rotated (14 11 13 9) row.
module inv_mix_single_column
    import AESDefinitions::*;
    import GaloisFieldFunctions::*;
(
    input  column_t col_in,
    output column_t col_out
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign col_out[gi] = GfMult14(col_in[gi])
                               ^ GfMult11(col_in[(gi + 1) % 4])
                               ^ GfMult13(col_in[(gi + 2) % 4])
                               ^ GfMult9(col_in[(gi + 3) % 4]);
        end
    endgenerate

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: one column per cycle through a shared column unit,
// with a ready/valid handshake on both sides.
module inv_mix_columns_seq
    import AESDefinitions::*;
(
    input  logic   clock,
    input  logic   reset,
    input  state_t in,
    input  logic   in_valid,
    output logic   in_ready,
    output state_t out,
    output logic   out_valid,
    input  logic   out_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t        fsm_reg, fsm_next;
    logic [1:0]  counter_reg, counter_next;
    state_t      state_reg, state_next;

    column_t     columns [4];
    column_t     col_sel;
    column_t     col_res;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign columns[gi] = {state_reg[4*gi+3], state_reg[4*gi+2],
                                  state_reg[4*gi+1], state_reg[4*gi]};
        end
    endgenerate

    assign col_sel = columns[counter_reg];

    inv_mix_single_column u_column (
        .col_in  (col_sel),
        .col_out (col_res)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_reg     <= IDLE;
            counter_reg <= 2'd0;
            state_reg   <= '0;
        end else begin
            fsm_reg     <= fsm_next;
            counter_reg <= counter_next;
            state_reg   <= state_next;
        end
    end

    always_comb begin
        fsm_next     = fsm_reg;
        counter_next = counter_reg;
        state_next   = state_reg;
        case (fsm_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next   = in;
                    counter_next = 2'd0;
                    fsm_next     = BUSY;
                end
            end
            BUSY: begin
                // Write the transformed column back into the slot it was read from.
                for (int r = 0; r < 4; r++) begin
                    state_next[{counter_reg, 2'(r)}] = col_res[r];
                end
                counter_next = counter_reg + 2'd1;
                if (counter_reg == 2'd3) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign in_ready  = (fsm_reg == IDLE);
    assign out_valid = (fsm_reg == DONE);
    assign out       = state_reg;

endmodule
